mips_mc_control: RTL and testbench
==================================

Name: mips_mc_control

Overview:
- Multi-cycle control unit for the non-pipelined MIPS core; sits directly upstream of the register file.
- Fetches and holds the current instruction, then sequences FETCH/DECODE/EXEC/MEM/WB.
- Drives register-file read/write addresses and write enable, ALU control, PC update and memory strobes.
- Inserts wait states on memory handshakes and traps on unsupported opcodes.

Parameters:
- PC_INC_SEL, 2'b00, pc_src encoding for PC+4.
- BR_SEL, 2'b01, pc_src encoding for branch target.
- JMP_SEL, 2'b10, pc_src encoding for jump target.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  32  instruction-memory read data; valid when mem_ready=1 in FETCH.
- mem_ready  in  1  memory handshake: access completes in the cycle it is high.
- alu_zero  in  1  ALU zero flag, valid in EXEC.
- ard1  out  5  register-file read address 1 = ir[25:21].
- ard2  out  5  register-file read address 2 = ir[20:16].
- awr  out  5  register-file write address: ir[15:11] for R-type, ir[20:16] for addi/lw.
- rf_wr_en  out  1  register-file write enable.
- wb_sel  out  1  write-back source: 0 = ALU result, 1 = memory data.
- alu_src_b  out  2  ALU B source: 00 = register, 01 = sign-extended immediate.
- alu_op  out  4  ALU operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
- ir_we  out  1  pulses when the instruction is latched.
- pc_we  out  1  PC write enable.
- pc_src  out  2  next-PC select.
- imem_rd  out  1  instruction-memory read strobe.
- dmem_rd  out  1  data-memory read strobe.
- dmem_wr  out  1  data-memory write strobe.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- illegal  out  1  high while in TRAP.

Behaviour:
- Reset (async, rst_n low):
  - state=FETCH, ir=0.
  - All outputs forced to 0 while rst_n is low, including imem_rd.
  - Reset mid-instruction abandons it: no rf_wr_en, no dmem_wr, no pc_we.
- Supported instructions:
  - R-type (op 0x00) with funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT.
  - addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
  - Anything else is illegal, including an unlisted funct.
- FETCH:
  - imem_rd=1.
  - If mem_ready: ir<=instr, ir_we=1, pc_we=1, pc_src=PC_INC_SEL, go to DECODE.
  - Otherwise stay in FETCH with ir_we=pc_we=0.
- DECODE: reads presented via ard1/ard2.
  - j: pc_we=1, pc_src=JMP_SEL, go to FETCH.
  - illegal: go to TRAP.
  - else: go to EXEC.
- EXEC:
  - R-type: alu_src_b=00, alu_op from funct, go to WB.
  - addi, lw, sw: alu_src_b=01, alu_op=ADD.
    - addi goes to WB; lw and sw go to MEM.
  - beq: alu_src_b=00, alu_op=SUB, pc_src=BR_SEL, pc_we=alu_zero, go to FETCH.
- MEM:
  - lw: dmem_rd=1; when mem_ready go to WB.
  - sw: dmem_wr=1; when mem_ready go to FETCH.
  - Strobes stay high for every stall cycle.
- WB:
  - rf_wr_en=1 for exactly one cycle; wb_sel=1 for lw, 0 otherwise; go to FETCH.
  - alu_op and alu_src_b hold their EXEC values.
- TRAP: sticky; illegal=1; all enables 0; exits only on reset.
- Output timing:
  - All outputs are combinational from state and ir; only ir_we, pc_we and the exits are gated by mem_ready and alu_zero.
  - Outputs not listed for a state are 0.
- Address stability: ard1, ard2 and awr are stable from DECODE through WB because ir changes only on ir_we.
- Writes to register 0: awr=0 still asserts rf_wr_en; the register file discards the write.
- Latency with zero-wait memory (mem_ready tied high), in cycles:
  - R-type 4, addi 4, lw 5, sw 4, beq 3, j 2.
  - Each low mem_ready cycle adds one cycle.
- rf_wr_en, dmem_wr and pc_we are never asserted in the same cycle, except that FETCH pc_we coincides with ir_we.

Test Plan:
- Reset and stall: hold rst_n=0, then release with mem_ready=0 for 3 cycles, then instr=0x012A4020 (add $8,$9,$10) with mem_ready=1.
  - All outputs are 0 during reset, state stays FETCH for the 3 stall cycles, then ir_we=pc_we=1.
  - Next: ard1=9, ard2=10; in EXEC alu_op=0010; in WB awr=8, rf_wr_en=1 for one cycle.
- lw with 2 wait states: instr=0x8D090004 (lw $9,4($8)).
  - EXEC has alu_src_b=01; dmem_rd is high for 3 MEM cycles.
  - WB has awr=9, wb_sel=1; 7 cycles total.
- sw: instr=0xAD090008.
  - dmem_wr=1 in MEM; rf_wr_en is never asserted; returns to FETCH after MEM.
- beq: instr=0x11090003.
  - With alu_zero=1 in EXEC: pc_we=1, pc_src=01.
  - Repeated with alu_zero=0: pc_we=0; 3 cycles each.
- j then illegal: instr=0x08000010 gives pc_we=1, pc_src=10 in DECODE.
  - Next instr=0xFC000000 enters TRAP, illegal=1, all strobes 0 for 10 cycles.
  - Async rst_n pulse returns to FETCH.
- Reset mid-WB: assert rst_n=0 during WB of an add.
  - rf_wr_en drops immediately (asynchronous) and state=FETCH after release.

Source files
------------

// File: rtl/mips_mc_control.sv
// Multi-cycle control unit for the non-pipelined MIPS core.
// Holds the fetched instruction and sequences FETCH/DECODE/EXEC/MEM/WB, trapping on unsupported opcodes.
module mips_mc_control #(
    parameter logic [1:0] PC_INC_SEL = 2'b00,
    parameter logic [1:0] BR_SEL     = 2'b01,
    parameter logic [1:0] JMP_SEL    = 2'b10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        alu_zero,
    output logic [4:0]  ard1,
    output logic [4:0]  ard2,
    output logic [4:0]  awr,
    output logic        rf_wr_en,
    output logic        wb_sel,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_op,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        imem_rd,
    output logic        dmem_rd,
    output logic        dmem_wr,
    output logic [2:0]  state,
    output logic        illegal
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_t      cur_state;
    state_t      next_state;
    logic [31:0] ir;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        is_rtype;
    logic        is_addi;
    logic        is_lw;
    logic        is_sw;
    logic        is_beq;
    logic        is_j;
    logic        is_legal;
    logic [3:0]  rtype_op;
    logic        unused_shamt;

    assign opcode       = ir[31:26];
    assign funct        = ir[5:0];
    assign unused_shamt = ^ir[10:6];

    // An R-type opcode with an unlisted funct counts as illegal.
    always_comb begin
        is_rtype = 1'b0;
        rtype_op = ALU_ADD;
        if (opcode == OP_RTYPE) begin
            is_rtype = 1'b1;
            case (funct)
                6'h20:   rtype_op = ALU_ADD;
                6'h22:   rtype_op = ALU_SUB;
                6'h24:   rtype_op = ALU_AND;
                6'h25:   rtype_op = ALU_OR;
                6'h2A:   rtype_op = ALU_SLT;
                default: is_rtype = 1'b0;
            endcase
        end
    end

    assign is_addi  = (opcode == OP_ADDI);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_j     = (opcode == OP_J);
    assign is_legal = is_rtype | is_addi | is_lw | is_sw | is_beq | is_j;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= FETCH;
            ir        <= '0;
        end else begin
            cur_state <= next_state;
            if (cur_state == FETCH && mem_ready) begin
                ir <= instr;
            end
        end
    end

    always_comb begin
        next_state = cur_state;
        ard1       = '0;
        ard2       = '0;
        awr        = '0;
        rf_wr_en   = 1'b0;
        wb_sel     = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = ALU_AND;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_INC_SEL;
        imem_rd    = 1'b0;
        dmem_rd    = 1'b0;
        dmem_wr    = 1'b0;
        illegal    = 1'b0;
        state      = cur_state;

        case (cur_state)
            FETCH: begin
                imem_rd = 1'b1;
                if (mem_ready) begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    pc_src     = PC_INC_SEL;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                if (is_j) begin
                    pc_we      = 1'b1;
                    pc_src     = JMP_SEL;
                    next_state = FETCH;
                end else if (!is_legal) begin
                    next_state = TRAP;
                end else begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                if (is_rtype) begin
                    alu_op     = rtype_op;
                    next_state = WB;
                end else if (is_addi || is_lw || is_sw) begin
                    alu_src_b  = 2'b01;
                    alu_op     = ALU_ADD;
                    next_state = is_addi ? WB : MEM;
                end else if (is_beq) begin
                    alu_op     = ALU_SUB;
                    pc_src     = BR_SEL;
                    pc_we      = alu_zero;
                    next_state = FETCH;
                end else begin
                    next_state = TRAP;
                end
            end
            MEM: begin
                if (is_lw) begin
                    dmem_rd = 1'b1;
                    if (mem_ready) next_state = WB;
                end else if (is_sw) begin
                    dmem_wr = 1'b1;
                    if (mem_ready) next_state = FETCH;
                end else begin
                    next_state = TRAP;
                end
            end
            WB: begin
                rf_wr_en   = 1'b1;
                wb_sel     = is_lw;
                alu_src_b  = is_rtype ? 2'b00 : 2'b01;
                alu_op     = is_rtype ? rtype_op : ALU_ADD;
                next_state = FETCH;
            end
            TRAP: begin
                illegal    = 1'b1;
                next_state = TRAP;
            end
            default: next_state = FETCH;
        endcase

        // Register addresses come straight from ir, which only changes in FETCH.
        if (cur_state inside {DECODE, EXEC, MEM, WB}) begin
            ard1 = ir[25:21];
            ard2 = ir[20:16];
            if (is_rtype)
                awr = ir[15:11];
            else if (is_addi || is_lw)
                awr = ir[20:16];
        end

        // Gating on rst_n makes an abandoned instruction lose its strobes at once.
        if (!rst_n) begin
            ard1      = '0;
            ard2      = '0;
            awr       = '0;
            rf_wr_en  = 1'b0;
            wb_sel    = 1'b0;
            alu_src_b = 2'b00;
            alu_op    = 4'b0000;
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            pc_src    = 2'b00;
            imem_rd   = 1'b0;
            dmem_rd   = 1'b0;
            dmem_wr   = 1'b0;
            illegal   = 1'b0;
            state     = 3'd0;
        end
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: each driven cycle pushes its expected outputs,
// and a negedge monitor pops and compares them field by field.
module tb_mips_mc_control;

    typedef struct packed {
        logic [2:0] state;
        logic       illegal;
        logic [4:0] ard1;
        logic [4:0] ard2;
        logic [4:0] awr;
        logic       rf_wr_en;
        logic       wb_sel;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       imem_rd;
        logic       dmem_rd;
        logic       dmem_wr;
    } outs_t;

    typedef struct {
        string tag;
        outs_t exp_o;
    } sb_entry_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        mem_ready;
    logic        alu_zero;
    logic [4:0]  ard1;
    logic [4:0]  ard2;
    logic [4:0]  awr;
    logic        rf_wr_en;
    logic        wb_sel;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_op;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        imem_rd;
    logic        dmem_rd;
    logic        dmem_wr;
    logic [2:0]  state;
    logic        illegal;

    sb_entry_t sb[$];
    int        checks = 0;
    int        errors = 0;

    mips_mc_control dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .mem_ready (mem_ready),
        .alu_zero  (alu_zero),
        .ard1      (ard1),
        .ard2      (ard2),
        .awr       (awr),
        .rf_wr_en  (rf_wr_en),
        .wb_sel    (wb_sel),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_src    (pc_src),
        .imem_rd   (imem_rd),
        .dmem_rd   (dmem_rd),
        .dmem_wr   (dmem_wr),
        .state     (state),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic rst, input logic pulse,
                                 input logic [31:0] ins, input logic rdy, input logic zero,
                                 input outs_t e);
        sb_entry_t ent;
        @(posedge clk);
        #1;
        instr     = ins;
        mem_ready = rdy;
        alu_zero  = zero;
        if (pulse) begin
            rst_n = 1'b0;
            #2;
            rst_n = 1'b1;
        end else begin
            rst_n = rst;
        end
        ent.tag   = tag;
        ent.exp_o = e;
        sb.push_back(ent);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_entry_t ent;
            ent = sb.pop_front();
            checkOutput({ent.tag, ".state"},     32'(state),     32'(ent.exp_o.state));
            checkOutput({ent.tag, ".illegal"},   32'(illegal),   32'(ent.exp_o.illegal));
            checkOutput({ent.tag, ".ard1"},      32'(ard1),      32'(ent.exp_o.ard1));
            checkOutput({ent.tag, ".ard2"},      32'(ard2),      32'(ent.exp_o.ard2));
            checkOutput({ent.tag, ".awr"},       32'(awr),       32'(ent.exp_o.awr));
            checkOutput({ent.tag, ".rf_wr_en"},  32'(rf_wr_en),  32'(ent.exp_o.rf_wr_en));
            checkOutput({ent.tag, ".wb_sel"},    32'(wb_sel),    32'(ent.exp_o.wb_sel));
            checkOutput({ent.tag, ".alu_src_b"}, 32'(alu_src_b), 32'(ent.exp_o.alu_src_b));
            checkOutput({ent.tag, ".alu_op"},    32'(alu_op),    32'(ent.exp_o.alu_op));
            checkOutput({ent.tag, ".ir_we"},     32'(ir_we),     32'(ent.exp_o.ir_we));
            checkOutput({ent.tag, ".pc_we"},     32'(pc_we),     32'(ent.exp_o.pc_we));
            checkOutput({ent.tag, ".pc_src"},    32'(pc_src),    32'(ent.exp_o.pc_src));
            checkOutput({ent.tag, ".imem_rd"},   32'(imem_rd),   32'(ent.exp_o.imem_rd));
            checkOutput({ent.tag, ".dmem_rd"},   32'(dmem_rd),   32'(ent.exp_o.dmem_rd));
            checkOutput({ent.tag, ".dmem_wr"},   32'(dmem_wr),   32'(ent.exp_o.dmem_wr));
        end
    end

    function automatic outs_t o_fetch(input logic rdy);
        outs_t e;
        e         = '0;
        e.imem_rd = 1'b1;
        e.ir_we   = rdy;
        e.pc_we   = rdy;
        return e;
    endfunction

    function automatic outs_t o_st(input logic [2:0] s, input logic [4:0] a1, input logic [4:0] a2,
                                   input logic [4:0] aw);
        outs_t e;
        e       = '0;
        e.state = s;
        e.ard1  = a1;
        e.ard2  = a2;
        e.awr   = aw;
        return e;
    endfunction

    localparam logic [31:0] I_ADD = 32'h012A4020;
    localparam logic [31:0] I_LW  = 32'h8D090004;
    localparam logic [31:0] I_SW  = 32'hAD090008;
    localparam logic [31:0] I_BEQ = 32'h11090003;
    localparam logic [31:0] I_J   = 32'h08000010;
    localparam logic [31:0] I_BAD = 32'hFC000000;
    localparam logic [31:0] JUNK  = 32'hFFFFFFFF;

    initial begin
        outs_t e;
        rst_n     = 1'b0;
        instr     = '0;
        mem_ready = 1'b0;
        alu_zero  = 1'b0;

        for (int i = 0; i < 3; i++)
            applyStimulus($sformatf("reset%0d", i), 1'b0, 1'b0, I_ADD, 1'b1, 1'b1, '0);
        for (int i = 0; i < 3; i++)
            applyStimulus($sformatf("stall%0d", i), 1'b1, 1'b0, I_ADD, 1'b0, 1'b0, o_fetch(1'b0));

        // add $8,$9,$10; instr is scrambled after the fetch to show ir holds it.
        applyStimulus("add.fetch", 1'b1, 1'b0, I_ADD, 1'b1, 1'b0, o_fetch(1'b1));
        applyStimulus("add.decode", 1'b1, 1'b0, JUNK, 1'b1, 1'b0, o_st(3'd1, 5'd9, 5'd10, 5'd8));
        e = o_st(3'd2, 5'd9, 5'd10, 5'd8); e.alu_op = 4'b0010;
        applyStimulus("add.exec", 1'b1, 1'b0, JUNK, 1'b1, 1'b0, e);
        e = o_st(3'd4, 5'd9, 5'd10, 5'd8); e.alu_op = 4'b0010; e.rf_wr_en = 1'b1;
        applyStimulus("add.wb", 1'b1, 1'b0, JUNK, 1'b1, 1'b0, e);

        // lw $9,4($8) with two memory wait states.
        applyStimulus("lw.fetch", 1'b1, 1'b0, I_LW, 1'b1, 1'b0, o_fetch(1'b1));
        applyStimulus("lw.decode", 1'b1, 1'b0, JUNK, 1'b1, 1'b0, o_st(3'd1, 5'd8, 5'd9, 5'd9));
        e = o_st(3'd2, 5'd8, 5'd9, 5'd9); e.alu_op = 4'b0010; e.alu_src_b = 2'b01;
        applyStimulus("lw.exec", 1'b1, 1'b0, JUNK, 1'b1, 1'b0, e);
        e = o_st(3'd3, 5'd8, 5'd9, 5'd9); e.dmem_rd = 1'b1;
        applyStimulus("lw.mem0", 1'b1, 1'b0, JUNK, 1'b0, 1'b0, e);
        applyStimulus("lw.mem1", 1'b1, 1'b0, JUNK, 1'b0, 1'b0, e);
        applyStimulus("lw.mem2", 1'b1, 1'b0, JUNK, 1'b1, 1'b0, e);
        e = o_st(3'd4, 5'd8, 5'd9, 5'd9); e.alu_op = 4'b0010; e.alu_src_b = 2'b01;
        e.rf_wr_en = 1'b1; e.wb_sel = 1'b1;
        applyStimulus("lw.wb", 1'b1, 1'b0, JUNK, 1'b1, 1'b0, e);

        // sw: no register write, straight back to FETCH after MEM.
        applyStimulus("sw.fetch", 1'b1, 1'b0, I_SW, 1'b1, 1'b0, o_fetch(1'b1));
        applyStimulus("sw.decode", 1'b1, 1'b0, JUNK, 1'b1, 1'b0, o_st(3'd1, 5'd8, 5'd9, 5'd0));
        e = o_st(3'd2, 5'd8, 5'd9, 5'd0); e.alu_op = 4'b0010; e.alu_src_b = 2'b01;
        applyStimulus("sw.exec", 1'b1, 1'b0, JUNK, 1'b1, 1'b0, e);
        e = o_st(3'd3, 5'd8, 5'd9, 5'd0); e.dmem_wr = 1'b1;
        applyStimulus("sw.mem", 1'b1, 1'b0, JUNK, 1'b1, 1'b0, e);

        // beq taken, then not taken.
        for (int k = 0; k < 2; k++) begin
            logic zero;
            zero = (k == 0);
            applyStimulus($sformatf("beq%0d.fetch", k), 1'b1, 1'b0, I_BEQ, 1'b1, 1'b0, o_fetch(1'b1));
            applyStimulus($sformatf("beq%0d.decode", k), 1'b1, 1'b0, JUNK, 1'b1, zero,
                          o_st(3'd1, 5'd8, 5'd9, 5'd0));
            e = o_st(3'd2, 5'd8, 5'd9, 5'd0); e.alu_op = 4'b0110; e.pc_src = 2'b01; e.pc_we = zero;
            applyStimulus($sformatf("beq%0d.exec", k), 1'b1, 1'b0, JUNK, 1'b1, zero, e);
        end

        applyStimulus("j.fetch", 1'b1, 1'b0, I_J, 1'b1, 1'b0, o_fetch(1'b1));
        e = o_st(3'd1, 5'd0, 5'd0, 5'd0); e.pc_we = 1'b1; e.pc_src = 2'b10;
        applyStimulus("j.decode", 1'b1, 1'b0, JUNK, 1'b1, 1'b0, e);

        // Unsupported opcode traps until an asynchronous reset pulse.
        applyStimulus("bad.fetch", 1'b1, 1'b0, I_BAD, 1'b1, 1'b0, o_fetch(1'b1));
        applyStimulus("bad.decode", 1'b1, 1'b0, JUNK, 1'b1, 1'b1, o_st(3'd1, 5'd0, 5'd0, 5'd0));
        e = o_st(3'd5, 5'd0, 5'd0, 5'd0); e.illegal = 1'b1;
        for (int i = 0; i < 10; i++)
            applyStimulus($sformatf("trap%0d", i), 1'b1, 1'b0, I_ADD, 1'b1, 1'b1, e);
        applyStimulus("trap.exit", 1'b1, 1'b1, I_ADD, 1'b0, 1'b0, o_fetch(1'b0));

        // A short reset pulse inside WB must abandon the write before the next edge.
        applyStimulus("rwb.fetch", 1'b1, 1'b0, I_ADD, 1'b1, 1'b0, o_fetch(1'b1));
        applyStimulus("rwb.decode", 1'b1, 1'b0, JUNK, 1'b1, 1'b0, o_st(3'd1, 5'd9, 5'd10, 5'd8));
        e = o_st(3'd2, 5'd9, 5'd10, 5'd8); e.alu_op = 4'b0010;
        applyStimulus("rwb.exec", 1'b1, 1'b0, JUNK, 1'b1, 1'b0, e);
        applyStimulus("rwb.pulse", 1'b1, 1'b1, JUNK, 1'b0, 1'b0, o_fetch(1'b0));

        // Reset held low through WB of an add.
        applyStimulus("hwb.fetch", 1'b1, 1'b0, I_ADD, 1'b1, 1'b0, o_fetch(1'b1));
        applyStimulus("hwb.decode", 1'b1, 1'b0, JUNK, 1'b1, 1'b0, o_st(3'd1, 5'd9, 5'd10, 5'd8));
        e = o_st(3'd2, 5'd9, 5'd10, 5'd8); e.alu_op = 4'b0010;
        applyStimulus("hwb.exec", 1'b1, 1'b0, JUNK, 1'b1, 1'b0, e);
        applyStimulus("hwb.reset", 1'b0, 1'b0, JUNK, 1'b1, 1'b0, '0);
        applyStimulus("hwb.release", 1'b1, 1'b0, JUNK, 1'b0, 1'b0, o_fetch(1'b0));

        @(negedge clk);
        #1;
        if (sb.size() != 0)
            checkOutput("sb_drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
